// File: rtl/vga_winmod_if.sv
// vga_winmod_if: scan position, image memory bus and window control for vga_winmod.
interface vga_winmod_if #(parameter int AW = 14, parameter int DW = 16);
    logic [20:0]   iAddr;
    logic [DW-1:0] iData;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] VGAD;
    logic [10:0]   iXOff;
    logic [9:0]    iYOff;
    logic [1:0]    iZoom;
    logic          iLoad;
    logic          oAck;
    logic          oPend;
    modport master (output iAddr, iData, iXOff, iYOff, iZoom, iLoad, input oAddr, VGAD, oAck, oPend);
    modport slave  (input iAddr, iData, iXOff, iYOff, iZoom, iLoad, output oAddr, VGAD, oAck, oPend);
endinterface

// File: rtl/vga_winmod.sv
// vga_winmod: zoomable image-window pixel fetcher, 2-cycle latency, settings applied at frame start.
// Optional VGA_WIN_COLORKEY_EN: pixels equal to KEY are replaced by BG.
module vga_winmod #(
    parameter int XW = 7,
    parameter int YSIZE = 96,
    parameter int AW = 14,
    parameter int DW = 16,
    parameter int HSTART = 296,
    parameter int VSTART = 35,
    parameter int HACT = 1024,
    parameter int VACT = 768,
    parameter logic [DW-1:0] BG = '0
`ifdef VGA_WIN_COLORKEY_EN
    , parameter logic [DW-1:0] KEY = 16'hF81F
`endif
) (
    input logic CLOCK,
    input logic RESET,
    vga_winmod_if.slave bus
);
    localparam int XSIZE = 1 << XW;
    logic [10:0]   sh_xoff_q, act_xoff_q;
    logic [9:0]    sh_yoff_q, act_yoff_q;
    logic [1:0]    sh_zoom_q, act_zoom_q, s;
    logic          pend_q, ack_q, win_q, win_d, apply;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] vgad_q, vgad_d, pix;
    logic [11:0]   dx, dy, xlim, ylim;
    assign apply = (bus.iAddr == '0) && pend_q;
    always_comb begin
        s = (act_zoom_q == 2'd3) ? 2'd0 : act_zoom_q;
        dx = {1'b0, bus.iAddr[20:10]} - 12'(HSTART) - {1'b0, act_xoff_q};
        dy = {2'b0, bus.iAddr[9:0]} - 12'(VSTART) - {2'b0, act_yoff_q};
        xlim = 12'(XSIZE) << s;
        ylim = 12'(YSIZE) << s;
        // sign bit catches positions left of / above the window
        win_d = !dx[11] && !dy[11] && dx < xlim && dy < ylim &&
                {1'b0, bus.iAddr[20:10]} < 12'(HSTART + HACT) &&
                {1'b0, bus.iAddr[9:0]} < 11'(VSTART + VACT);
        addr_d = win_d ? AW'((32'(dy >> s) << XW) + 32'(dx >> s)) : '0;
`ifdef VGA_WIN_COLORKEY_EN
        pix = (bus.iData == KEY) ? BG : bus.iData;
`else
        pix = bus.iData;
`endif
        vgad_d = win_q ? pix : BG;
    end
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sh_xoff_q <= '0;
            sh_yoff_q <= '0;
            sh_zoom_q <= '0;
            act_xoff_q <= '0;
            act_yoff_q <= '0;
            act_zoom_q <= '0;
            pend_q <= 1'b0;
            ack_q <= 1'b0;
            win_q <= 1'b0;
            addr_q <= '0;
            vgad_q <= '0;
        end else begin
            ack_q <= apply;
            if (apply) begin
                act_xoff_q <= sh_xoff_q;
                act_yoff_q <= sh_yoff_q;
                act_zoom_q <= sh_zoom_q;
                pend_q <= 1'b0;
            end
            // a load on the frame-start cycle waits for the following frame
            if (bus.iLoad) begin
                sh_xoff_q <= bus.iXOff;
                sh_yoff_q <= bus.iYOff;
                sh_zoom_q <= bus.iZoom;
                pend_q <= 1'b1;
            end
            win_q <= win_d;
            addr_q <= addr_d;
            vgad_q <= vgad_d;
        end
    end
    assign bus.oAddr = addr_q;
    assign bus.VGAD = vgad_q;
    assign bus.oAck = ack_q;
    assign bus.oPend = pend_q;
endmodule

// File: tb/tb_vga_winmod.sv
// tb_vga_winmod: directed vectors for vga_winmod with a synthetic image memory.
module tb_vga_winmod;
    localparam logic [15:0] BG = 16'h0000;
    localparam logic [20:0] IDLE = {11'd0, 10'd1};
    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    logic ovr = 1'b0;
    logic [15:0] ovr_val = '0;
    int nvec = 0;
    int nerr = 0;
    vga_winmod_if #(.AW(14), .DW(16)) bus ();
    vga_winmod dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));
    always #5 CLOCK = ~CLOCK;
    function automatic logic [15:0] mem(input logic [13:0] a);
        return {2'b10, a};
    endfunction
    assign bus.iData = ovr ? ovr_val : mem(bus.oAddr);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask
    task automatic pix(input int x, input int y, input logic [31:0] ea, input logic [31:0] ev);
        bus.iAddr = {11'(x), 10'(y)};
        tick();
        chk($sformatf("oAddr(%0d,%0d)", x, y), 32'(bus.oAddr), ea);
        bus.iAddr = IDLE;
        tick();
        chk($sformatf("VGAD(%0d,%0d)", x, y), 32'(bus.VGAD), ev);
    endtask
    task automatic load(input int x, input int y, input int z);
        bus.iXOff = 11'(x);
        bus.iYOff = 10'(y);
        bus.iZoom = 2'(z);
        bus.iLoad = 1'b1;
        tick();
        bus.iLoad = 1'b0;
    endtask
    task automatic frame();
        bus.iAddr = '0;
        tick();
        bus.iAddr = IDLE;
    endtask
    initial begin
        bus.iAddr = IDLE;
        bus.iXOff = '0;
        bus.iYOff = '0;
        bus.iZoom = '0;
        bus.iLoad = 1'b0;
        repeat (3) tick();
        chk("rst_addr", 32'(bus.oAddr), 0);
        chk("rst_vgad", 32'(bus.VGAD), 0);
        chk("rst_ack", 32'(bus.oAck), 0);
        chk("rst_pend", 32'(bus.oPend), 0);
        RESET = 1'b1;
        pix(296, 35, 0, mem(0));
        pix(423, 130, 12287, mem(12287));
        pix(424, 130, 0, BG);
        pix(295, 35, 0, BG);
        pix(296, 131, 0, BG);
        load(100, 50, 1);
        chk("pend_set", 32'(bus.oPend), 1);
        chk("ack_early", 32'(bus.oAck), 0);
        pix(296, 35, 0, mem(0));
        pix(396, 85, 6500, mem(6500));
        frame();
        chk("ack_pulse", 32'(bus.oAck), 1);
        chk("pend_clr", 32'(bus.oPend), 0);
        tick();
        chk("ack_once", 32'(bus.oAck), 0);
        pix(398, 87, 129, mem(129));
        pix(396, 85, 0, mem(0));
        pix(651, 276, 12287, mem(12287));
        pix(652, 85, 0, BG);
        pix(396, 277, 0, BG);
        pix(395, 85, 0, BG);
        load(10, 0, 0);
        load(20, 0, 0);
        frame();
        chk("dbl_ack", 32'(bus.oAck), 1);
        tick();
        frame();
        chk("dbl_ack_once", 32'(bus.oAck), 0);
        pix(316, 35, 0, mem(0));
        pix(315, 35, 0, BG);
        bus.iXOff = 11'd30;
        bus.iLoad = 1'b1;
        bus.iAddr = '0;
        tick();
        bus.iLoad = 1'b0;
        bus.iAddr = IDLE;
        chk("fs_load_ack", 32'(bus.oAck), 0);
        chk("fs_load_pend", 32'(bus.oPend), 1);
        pix(316, 35, 0, mem(0));
        frame();
        chk("fs_load_apply", 32'(bus.oAck), 1);
        pix(326, 35, 0, mem(0));
        pix(325, 35, 0, BG);
        load(950, 0, 0);
        frame();
        pix(1319, 35, 73, mem(73));
        pix(1320, 35, 0, BG);
        ovr = 1'b1;
        ovr_val = 16'hF81F;
`ifdef VGA_WIN_COLORKEY_EN
        pix(1319, 35, 73, BG);
`else
        pix(1319, 35, 73, 16'hF81F);
`endif
        ovr_val = 16'h07E0;
        pix(1319, 35, 73, 16'h07E0);
        ovr = 1'b0;
        load(100, 50, 1);
        chk("pend_before_rst", 32'(bus.oPend), 1);
        bus.iAddr = {11'd1319, 10'd35};
        tick();
        chk("addr_before_rst", 32'(bus.oAddr), 73);
        RESET = 1'b0;
        #1;
        chk("rst_mid_addr", 32'(bus.oAddr), 0);
        chk("rst_mid_vgad", 32'(bus.VGAD), 0);
        chk("rst_mid_pend", 32'(bus.oPend), 0);
        bus.iAddr = IDLE;
        tick();
        tick();
        RESET = 1'b1;
        frame();
        chk("rst_no_ack", 32'(bus.oAck), 0);
        pix(296, 35, 0, mem(0));
        pix(423, 130, 12287, mem(12287));
        pix(424, 130, 0, BG);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/vga_winmod.md
# vga_winmod

Parametrised image-window pixel fetcher for the VGA path. It receives the current scan position from the sync generator and addresses an image ROM/RAM for a rectangular window whose offset and integer zoom are programmable at run time. It outputs the RGB word to the VGA pins after a fixed 2-cycle pipeline. Window updates are double-buffered and take effect only at frame start, so a frame never tears.

## Interface
Parameters:
- XW, 7: log2 of image width; XSIZE = 2^XW = 128 pixels
- YSIZE, 96: image height in lines
- AW, 14: image memory address width; must satisfy 2^AW >= XSIZE*YSIZE
- DW, 16: pixel data width (RGB565)
- HSTART, 296: first active X count (sync + back porch)
- VSTART, 35: first active Y count
- HACT, 1024: active width; VACT, 768: active height
- BG, 16'h0000: colour driven outside the window

Ports:
- CLOCK  in  1  pixel clock
- RESET  in  1  asynchronous, active-low
- iAddr  in  21  scan position, [20:10] X count, [9:0] Y count
- iData  in  DW  image memory read data, valid 1 cycle after oAddr
- oAddr  out  AW  image memory read address
- VGAD  out  DW  pixel to DAC
- iXOff  in  11  window X offset within active area
- iYOff  in  10  window Y offset within active area
- iZoom  in  2  0 = 1x, 1 = 2x, 2 = 4x, 3 = reserved (treated as 1x)
- iLoad  in  1  one-cycle request to capture iXOff/iYOff/iZoom
- oAck  out  1  one-cycle pulse when the captured settings become active
- oPend  out  1  high while captured settings await frame start

## Operation
- Shadow set {XOff,YOff,Zoom} captured on iLoad; oPend set. A second iLoad while pending overwrites the shadow, with no extra oAck.
- Active set loads from shadow on the cycle iAddr == 0 (frame start) when oPend = 1. The same edge pulses oAck and clears oPend.
- iLoad on the frame-start cycle is captured to shadow and applied at the next frame start, not the current one.
- Window test, using active set and shift s = Zoom (0/1/2):
  - X term: dx = X - HSTART - XOff, window when 0 <= dx < (XSIZE<<s).
  - Y term: dy = Y - VSTART - YOff, window when 0 <= dy < (YSIZE<<s).
  - Active-area term: window also requires X < HSTART+HACT and Y < VSTART+VACT, so the window is clipped at the active edge.
  - Arithmetic: dx/dy computed 12-bit signed; a negative value means outside the window.
- Address: oAddr = ((dy>>s) << XW) + (dx>>s), truncated to AW bits. Outside the window, oAddr = 0.
- Output: VGAD = iData when the window flag delayed one stage is set, else BG.
- Reset: active and shadow sets = 0 (zoom 1x), oPend = 0, oAck = 0, oAddr = 0, VGAD = 0 (not BG). All pipeline valid flags = 0.

## Timing
- Cycle n: iAddr presented.
- Edge n+1: oAddr and window flag registered.
- Edge n+2: VGAD registered from iData and the delayed flag. Total latency is 2 cycles, independent of zoom.
- oAck is high for exactly 1 cycle, on the cycle after the frame-start edge.
- Reset assertion mid-frame clears the pipeline immediately. The first valid VGAD appears 2 cycles after release.

## Configuration
- VGA_WIN_COLORKEY_EN:
  - Defined: adds parameter KEY (default 16'hF81F). A fetched pixel equal to KEY outputs BG instead, giving transparent sprite pixels. Latency is unchanged.
  - Undefined: every in-window pixel outputs iData unmodified.

## Test plan
- Reset, 1x zoom, offset 0: scan X=296,Y=35 -> oAddr=0 after 1 cycle, VGAD=iData after 2 cycles. Scan X=423,Y=130 -> oAddr=95*128+127=12287. X=424 -> VGAD=BG.
- iLoad with XOff=100, YOff=50, Zoom=1 mid-frame: oPend=1 and the window is unchanged until iAddr==0. Then oAck pulses once, oPend=0. Pixel X=396..651, Y=85..276 in window. X=398,Y=87 -> oAddr=(1<<7)+1=129.
- Two iLoads before frame start (XOff 10, then 20): a single oAck; the window starts at X=316.
- Clipping: XOff=950, Zoom=0: pixels X>=1320 output BG. The pixel at X=1319 fetches oAddr x=73.
- Colorkey (macro defined): in-window iData=16'hF81F -> VGAD=BG. iData=16'h07E0 -> VGAD=16'h07E0. With the macro undefined, F81F passes through.
- Reset asserted during a pending load: oPend=0, no oAck at the next frame, window back to offset 0, 1x.
